// File: rtl/softusb_pkg.sv
// rtl/softusb_pkg.sv - shared state, mode and CRC constants for the softusb transmit path
//
// Purpose: state encoding, crc_mode codes, CRC5/CRC16 presets, polynomials and
// receiver residuals, plus the serial CRC update helpers used by the LFSR.
// Ports: none (package).
package softusb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PID     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_FIN     = 3'd4
  } tx_state_e;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_CRC5  = 2'b01;
  localparam logic [1:0] MODE_CRC16 = 2'b10;

  localparam logic [4:0]  CRC5_PRESET    = 5'h1F;
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Feedback enters bit 0; the register moves toward the MSB.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic din);
    crc5_next = {crc[3:0], 1'b0} ^ ((crc[4] ^ din) ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    crc16_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/softusb_txcrc_lfsr.sv
// rtl/softusb_txcrc_lfsr.sv - serial CRC5/CRC16 update and shift-out register
//
// Purpose: holds the running CRC of the payload and, once the payload is done,
// shifts it out MSB first in complemented form.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   sel16_i  - 1 selects CRC16, 0 selects CRC5
//   preset_i - load all-ones into both registers
//   update_i - fold din_i into the selected CRC
//   din_i    - payload bit
//   shift_i  - advance the selected register one bit toward the MSB, 1 fill
//   out_o    - complemented MSB of the selected register (next CRC bit on wire)
// Configuration: SOFTUSB_TXCRC_CRC5_EN builds the CRC5 register; without it
// only CRC16 exists.
module softusb_txcrc_lfsr
  import softusb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel16_i,
  input  logic preset_i,
  input  logic update_i,
  input  logic din_i,
  input  logic shift_i,
  output logic out_o
);

  logic [15:0] crc16_q;
  logic [15:0] crc16_d;

  always_comb begin
    crc16_d = crc16_q;
    if (preset_i) begin
      crc16_d = CRC16_PRESET;
    end else if (sel16_i && update_i) begin
      crc16_d = crc16_next(crc16_q, din_i);
    end else if (sel16_i && shift_i) begin
      crc16_d = {crc16_q[14:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc16_q <= CRC16_PRESET;
    end else begin
      crc16_q <= crc16_d;
    end
  end

`ifdef SOFTUSB_TXCRC_CRC5_EN
  logic [4:0] crc5_q;
  logic [4:0] crc5_d;

  always_comb begin
    crc5_d = crc5_q;
    if (preset_i) begin
      crc5_d = CRC5_PRESET;
    end else if (!sel16_i && update_i) begin
      crc5_d = crc5_next(crc5_q, din_i);
    end else if (!sel16_i && shift_i) begin
      crc5_d = {crc5_q[3:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc5_q <= CRC5_PRESET;
    end else begin
      crc5_q <= crc5_d;
    end
  end

  assign out_o = sel16_i ? ~crc16_q[15] : ~crc5_q[4];
`else
  assign out_o = ~crc16_q[15];
`endif

endmodule

// File: rtl/softusb_txcrc.sv
// rtl/softusb_txcrc.sv - softusb transmit serializer with CRC5/CRC16 append
//
// Purpose: takes a PID byte plus payload bytes over valid/ready, shifts them out
// LSB first one bit per tx_strobe, and appends the complemented CRC.
// Ports:
//   usb_clk, usb_rst          - clock, synchronous active-high reset
//   tx_strobe                 - bit-slot enable
//   start, crc_mode           - begin packet (idle only); 00 none, 01 CRC5, 10 CRC16
//   data_in, data_valid,
//   data_last, data_ready     - byte handshake; data_last ends a CRC16 payload
//   tx_bit, tx_bit_valid      - serialized bit and its one-cycle qualifier
//   busy, done, underrun      - packet in progress / completed / aborted
// Configuration: SOFTUSB_TXCRC_CRC5_EN builds token (CRC5) mode; without it
// crc_mode 01 behaves as 00.
module softusb_txcrc
  import softusb_pkg::*;
(
  input  logic       usb_clk,
  input  logic       usb_rst,
  input  logic       tx_strobe,
  input  logic       start,
  input  logic [1:0] crc_mode,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       tx_bit_valid,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  tx_state_e   state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;    // bytes accepted, saturating at 3
  logic        got_last_q, got_last_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;  // bits of the held byte that go on the wire
  logic        hold_pid_q, hold_pid_d;
  logic        hold_last_q, hold_last_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic        sh_pid_q, sh_pid_d;
  logic        sh_last_q, sh_last_d;
  logic [4:0]  crc_cnt_q, crc_cnt_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_bit_valid_q, tx_bit_valid_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;

  logic [1:0]  start_mode;
  logic        more_exp;
  logic        accept;
  logic        in_pid;
  logic        in_last;
  logic [3:0]  in_cnt;
  logic [7:0]  eff_byte;
  logic [3:0]  eff_cnt;
  logic        eff_pid;
  logic        eff_last;
  logic        hold_take;
  logic        in_to_sh;
  logic        lfsr_preset;
  logic        lfsr_update;
  logic        lfsr_din;
  logic        lfsr_shift;
  logic        lfsr_out;

  always_comb begin
    start_mode = MODE_NONE;
    if (crc_mode == MODE_CRC16) begin
      start_mode = MODE_CRC16;
    end
`ifdef SOFTUSB_TXCRC_CRC5_EN
    else if (crc_mode == MODE_CRC5) begin
      start_mode = MODE_CRC5;
    end
`endif
  end

  // Which bytes are still owed and how the incoming one is classified.
  always_comb begin
    more_exp = (acc_cnt_q == 2'd0);
    in_pid   = (acc_cnt_q == 2'd0);
    in_last  = 1'b1;
    in_cnt   = 4'd8;
    case (mode_q)
      MODE_CRC16: begin
        more_exp = !got_last_q;
        in_last  = data_last;
      end
`ifdef SOFTUSB_TXCRC_CRC5_EN
      MODE_CRC5: begin
        // PID plus exactly two payload bytes; only 3 bits of the second go out.
        more_exp = (acc_cnt_q != 2'd3);
        in_last  = (acc_cnt_q == 2'd2);
        if (acc_cnt_q == 2'd2) begin
          in_cnt = 4'd3;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  assign data_ready = !hold_full_q && more_exp &&
                      ((state_q == S_PID) || (state_q == S_PAYLOAD));
  assign accept     = data_valid && data_ready;

  // Effective shifter: an empty shifter is refilled from the holding register
  // or, failing that, straight from data_in in the same cycle, so a strobe never
  // has to wait a cycle for the refill.
  always_comb begin
    eff_byte  = sh_q;
    eff_cnt   = sh_cnt_q;
    eff_pid   = sh_pid_q;
    eff_last  = sh_last_q;
    hold_take = 1'b0;
    in_to_sh  = 1'b0;
    if (sh_cnt_q == 4'd0) begin
      if (hold_full_q) begin
        eff_byte  = hold_q;
        eff_cnt   = hold_cnt_q;
        eff_pid   = hold_pid_q;
        eff_last  = hold_last_q;
        hold_take = 1'b1;
      end else if (accept) begin
        eff_byte  = data_in;
        eff_cnt   = in_cnt;
        eff_pid   = in_pid;
        eff_last  = in_last;
        in_to_sh  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    acc_cnt_d      = acc_cnt_q;
    got_last_d     = got_last_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    hold_cnt_d     = hold_cnt_q;
    hold_pid_d     = hold_pid_q;
    hold_last_d    = hold_last_q;
    sh_d           = sh_q;
    sh_cnt_d       = sh_cnt_q;
    sh_pid_d       = sh_pid_q;
    sh_last_d      = sh_last_q;
    crc_cnt_d      = crc_cnt_q;
    tx_bit_d       = tx_bit_q;
    tx_bit_valid_d = 1'b0;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    lfsr_preset    = 1'b0;
    lfsr_update    = 1'b0;
    lfsr_din       = 1'b0;
    lfsr_shift     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PID;
          mode_d      = start_mode;
          acc_cnt_d   = 2'd0;
          got_last_d  = 1'b0;
          hold_full_d = 1'b0;
          sh_cnt_d    = 4'd0;
          lfsr_preset = 1'b1;
        end
      end

      S_PID, S_PAYLOAD: begin
        if (accept) begin
          if (acc_cnt_q != 2'd3) begin
            acc_cnt_d = acc_cnt_q + 2'd1;
          end
          if (mode_q == MODE_CRC16 && data_last) begin
            got_last_d = 1'b1;
          end
        end
        if (hold_take) begin
          hold_full_d = 1'b0;
        end
        if (accept && !in_to_sh) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
          hold_cnt_d  = in_cnt;
          hold_pid_d  = in_pid;
          hold_last_d = in_last;
        end
        sh_d      = eff_byte;
        sh_cnt_d  = eff_cnt;
        sh_pid_d  = eff_pid;
        sh_last_d = eff_last;

        if (tx_strobe) begin
          if (eff_cnt == 4'd0) begin
            underrun_d  = 1'b1;
            state_d     = S_IDLE;
            hold_full_d = 1'b0;
            sh_cnt_d    = 4'd0;
          end else begin
            tx_bit_d       = eff_byte[0];
            tx_bit_valid_d = 1'b1;
            lfsr_update    = !eff_pid;
            lfsr_din       = eff_byte[0];
            sh_d           = {1'b0, eff_byte[7:1]};
            sh_cnt_d       = eff_cnt - 4'd1;
            if (eff_cnt == 4'd1) begin
              if (eff_last) begin
                if (mode_q == MODE_NONE) begin
                  state_d = S_FIN;
                end else begin
                  state_d   = S_CRC;
                  crc_cnt_d = (mode_q == MODE_CRC16) ? 5'd16 : 5'd5;
                end
              end else if (eff_pid) begin
                state_d = S_PAYLOAD;
              end
            end
          end
        end
      end

      S_CRC: begin
        if (tx_strobe) begin
          tx_bit_d       = lfsr_out;
          tx_bit_valid_d = 1'b1;
          lfsr_shift     = 1'b1;
          crc_cnt_d      = crc_cnt_q - 5'd1;
          if (crc_cnt_q == 5'd1) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q        <= S_IDLE;
      mode_q         <= MODE_NONE;
      acc_cnt_q      <= 2'd0;
      got_last_q     <= 1'b0;
      hold_q         <= 8'h00;
      hold_full_q    <= 1'b0;
      hold_cnt_q     <= 4'd0;
      hold_pid_q     <= 1'b0;
      hold_last_q    <= 1'b0;
      sh_q           <= 8'h00;
      sh_cnt_q       <= 4'd0;
      sh_pid_q       <= 1'b0;
      sh_last_q      <= 1'b0;
      crc_cnt_q      <= 5'd0;
      tx_bit_q       <= 1'b0;
      tx_bit_valid_q <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      acc_cnt_q      <= acc_cnt_d;
      got_last_q     <= got_last_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_pid_q     <= hold_pid_d;
      hold_last_q    <= hold_last_d;
      sh_q           <= sh_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_pid_q       <= sh_pid_d;
      sh_last_q      <= sh_last_d;
      crc_cnt_q      <= crc_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_bit_valid_q <= tx_bit_valid_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
    end
  end

  softusb_txcrc_lfsr u_lfsr (
    .clk_i    (usb_clk),
    .rst_i    (usb_rst),
    .sel16_i  (mode_q == MODE_CRC16),
    .preset_i (lfsr_preset),
    .update_i (lfsr_update),
    .din_i    (lfsr_din),
    .shift_i  (lfsr_shift),
    .out_o    (lfsr_out)
  );

  assign tx_bit       = tx_bit_q;
  assign tx_bit_valid = tx_bit_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign underrun     = underrun_q;

endmodule
